// File: rtl/mem_access_pkg.sv
// Shared types and size encodings for the byte-addressed load/store front end.
// The size codes match the data memory's MByte decoding.
package mem_access_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      READ  = 2'b01,
      WRITE = 2'b10,
      RESP  = 2'b11
   } accState_t;

   localparam logic [1:0] SIZE_WORD = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_BYTE = 2'b10;

   // Size code 2'b11 behaves like a word access.
   function automatic logic isWordSize(input logic [1:0] size);
      return (size != SIZE_HALF) && (size != SIZE_BYTE);
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane handling: load extract/extend, store lane merge,
// and the alignment check applied to incoming requests.
module mem_lane_align
   import mem_access_pkg::*;
(
   input  logic [1:0]  laneOffset,
   input  logic [1:0]  laneSize,
   input  logic        laneSigned,
   input  logic [31:0] rdWord,
   input  logic [31:0] wData,
   input  logic [1:0]  chkOffset,
   input  logic [1:0]  chkSize,
   output logic [31:0] loadData,
   output logic [31:0] mergedWord,
   output logic        misaligned
);

   logic [7:0]  byteSel;
   logic [15:0] halfSel;
   logic [4:0]  bitBase;

   assign bitBase = {laneOffset, 3'b000};
   assign byteSel = rdWord[bitBase +: 8];
   assign halfSel = laneOffset[1] ? rdWord[31:16] : rdWord[15:0];

   always_comb begin
      loadData = rdWord;
      case (laneSize)
         SIZE_BYTE: loadData = {{24{laneSigned & byteSel[7]}}, byteSel};
         SIZE_HALF: loadData = {{16{laneSigned & halfSel[15]}}, halfSel};
         default:   loadData = rdWord;
      endcase
   end

   always_comb begin
      mergedWord = rdWord;
      case (laneSize)
         SIZE_BYTE: mergedWord[bitBase +: 8] = wData[7:0];
         SIZE_HALF: begin
            if (laneOffset[1]) mergedWord[31:16] = wData[15:0];
            else               mergedWord[15:0]  = wData[15:0];
         end
         default:   mergedWord = wData;
      endcase
   end

   always_comb begin
      misaligned = 1'b0;
      case (chkSize)
         SIZE_BYTE: misaligned = 1'b0;
         SIZE_HALF: misaligned = chkOffset[0];
         default:   misaligned = |chkOffset;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end between the MEM stage and a word-addressed data memory.
// One request at a time; sub-word stores at any offset go through read-modify-write.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int ADDR_W = 6
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        ReqValid,
   output logic        ReqReady,
   input  logic        ReqWrite,
   input  logic [1:0]  ReqSize,
   input  logic        ReqSigned,
   input  logic [31:0] ReqAddr,
   input  logic [31:0] ReqWData,
   output logic        RespValid,
   output logic [31:0] RespRData,
   output logic        RespErr,
   output logic [31:0] MemAddress,
   output logic [31:0] MemWriteData,
   output logic        MemRead,
   output logic        MemWrite,
   output logic [1:0]  MByte,
   input  logic [31:0] MemReadData
);

   accState_t         state;
   logic [ADDR_W-1:0] wordIdxQ;
   logic [1:0]        offsQ;
   logic [1:0]        sizeQ;
   logic              signedQ;
   logic              writeQ;
   logic [31:0]       wDataQ;

   logic [ADDR_W-1:0] memAddrQ;
   logic [31:0]       memWDataQ;
   logic              memReadQ;
   logic              memWriteQ;
   logic              respValidQ;
   logic              respErrQ;
   logic [31:0]       respRDataQ;

   logic [31:0]       loadData;
   logic [31:0]       mergedWord;
   logic              misaligned;

   // Address bits above the memory depth are ignored.
   logic unusedAddrBits;
   assign unusedAddrBits = ^ReqAddr[31:ADDR_W+2];

   mem_lane_align uAlign (
      .laneOffset (offsQ),
      .laneSize   (sizeQ),
      .laneSigned (signedQ),
      .rdWord     (MemReadData),
      .wData      (wDataQ),
      .chkOffset  (ReqAddr[1:0]),
      .chkSize    (ReqSize),
      .loadData   (loadData),
      .mergedWord (mergedWord),
      .misaligned (misaligned)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= IDLE;
         wordIdxQ   <= '0;
         offsQ      <= '0;
         sizeQ      <= '0;
         signedQ    <= 1'b0;
         writeQ     <= 1'b0;
         wDataQ     <= '0;
         memAddrQ   <= '0;
         memWDataQ  <= '0;
         memReadQ   <= 1'b0;
         memWriteQ  <= 1'b0;
         respValidQ <= 1'b0;
         respErrQ   <= 1'b0;
         respRDataQ <= '0;
      end else begin
         memAddrQ   <= '0;
         memWDataQ  <= '0;
         memReadQ   <= 1'b0;
         memWriteQ  <= 1'b0;
         respValidQ <= 1'b0;
         respErrQ   <= 1'b0;
         respRDataQ <= '0;
         case (state)
            IDLE: begin
               if (ReqValid) begin
                  wordIdxQ <= ReqAddr[ADDR_W+1:2];
                  offsQ    <= ReqAddr[1:0];
                  sizeQ    <= ReqSize;
                  signedQ  <= ReqSigned;
                  writeQ   <= ReqWrite;
                  wDataQ   <= ReqWData;
                  if (misaligned) begin
                     state      <= RESP;
                     respValidQ <= 1'b1;
                     respErrQ   <= 1'b1;
                  end else if (ReqWrite && isWordSize(ReqSize)) begin
                     state     <= WRITE;
                     memWriteQ <= 1'b1;
                     memAddrQ  <= ReqAddr[ADDR_W+1:2];
                     memWDataQ <= ReqWData;
                  end else begin
                     state    <= READ;
                     memReadQ <= 1'b1;
                     memAddrQ <= ReqAddr[ADDR_W+1:2];
                  end
               end
            end
            READ: begin
               if (writeQ) begin
                  state     <= WRITE;
                  memWriteQ <= 1'b1;
                  memAddrQ  <= wordIdxQ;
                  memWDataQ <= mergedWord;
               end else begin
                  state      <= RESP;
                  respValidQ <= 1'b1;
                  respRDataQ <= loadData;
               end
            end
            WRITE: begin
               state      <= RESP;
               respValidQ <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign ReqReady     = (state == IDLE);
   assign MemRead      = memReadQ;
   assign MemWrite     = memWriteQ;
   assign MemAddress   = {{(32-ADDR_W){1'b0}}, memAddrQ};
   assign MemWriteData = memWDataQ;
   assign MByte        = SIZE_WORD;
   assign RespValid    = respValidQ;
   assign RespErr      = respErrQ;
   assign RespRData    = respRDataQ;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small word-addressed memory model
// that reads combinationally and commits writes on the negedge.
module tb_mem_access_unit;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        ReqValid;
   logic        ReqReady;
   logic        ReqWrite;
   logic [1:0]  ReqSize;
   logic        ReqSigned;
   logic [31:0] ReqAddr;
   logic [31:0] ReqWData;
   logic        RespValid;
   logic [31:0] RespRData;
   logic        RespErr;
   logic [31:0] MemAddress;
   logic [31:0] MemWriteData;
   logic        MemRead;
   logic        MemWrite;
   logic [1:0]  MByte;
   logic [31:0] MemReadData;

   logic [31:0] mem [64];
   int checkCount = 0;
   int passCount  = 0;

   always #5 Clk = ~Clk;

   mem_access_unit #(.ADDR_W(6)) dut (
      .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
      .ReqWrite(ReqWrite), .ReqSize(ReqSize), .ReqSigned(ReqSigned),
      .ReqAddr(ReqAddr), .ReqWData(ReqWData), .RespValid(RespValid),
      .RespRData(RespRData), .RespErr(RespErr), .MemAddress(MemAddress),
      .MemWriteData(MemWriteData), .MemRead(MemRead), .MemWrite(MemWrite),
      .MByte(MByte), .MemReadData(MemReadData)
   );

   assign MemReadData = mem[MemAddress[5:0]];

   always @(negedge Clk) begin
      if (MemWrite) mem[MemAddress[5:0]] <= MemWriteData;
   end

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got === exp) passCount++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Issues one request and traces cycles N+1.. relative to acceptance.
   task automatic runReq(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output int respCyc, output logic [31:0] rdata, output logic err,
                         output logic [15:0] rdMask, output logic [15:0] wrMask,
                         output logic mbBad, output logic [31:0] addrSeen);
      @(negedge Clk);
      ReqWrite = wr; ReqSize = sz; ReqSigned = sg; ReqAddr = addr; ReqWData = wd;
      ReqValid = 1'b1;
      @(posedge Clk);
      #1 ReqValid = 1'b0;
      respCyc = -1; rdata = 'x; err = 1'bx;
      rdMask = '0; wrMask = '0; mbBad = 1'b0; addrSeen = '0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge Clk);
         if (MemRead) begin rdMask[c] = 1'b1; addrSeen = MemAddress; end
         if (MemWrite) begin wrMask[c] = 1'b1; addrSeen = MemAddress; end
         if (MByte != 2'b00) mbBad = 1'b1;
         if (RespValid) begin
            respCyc = c; rdata = RespRData; err = RespErr;
            break;
         end
      end
   endtask

   int          respCyc;
   logic [31:0] rdata;
   logic        err;
   logic [15:0] rdMask, wrMask;
   logic        mbBad;
   logic [31:0] addrSeen;
   logic        sawBad;
   logic [7:0]  validTrace, readyTrace;
   logic [31:0] secondData;

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = '0;
      mem[1] = 32'h00F08000;
      mem[2] = 32'h11223344;
      mem[3] = 32'h8899AABB;
      Reset = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0; ReqSize = 2'b00;
      ReqSigned = 1'b0; ReqAddr = '0; ReqWData = '0;
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      checkVal("rst_ready",    {31'b0, ReqReady},  32'd1);
      checkVal("rst_resp",     {30'b0, RespValid, RespErr}, 32'd0);
      checkVal("rst_strobes",  {30'b0, MemRead, MemWrite}, 32'd0);
      checkVal("rst_addr",     MemAddress, 32'd0);
      checkVal("rst_rdata",    RespRData, 32'd0);

      // word load
      runReq(1'b0, 2'b00, 1'b0, 32'h0C, 32'h0, respCyc, rdata, err, rdMask, wrMask, mbBad, addrSeen);
      checkVal("lw_cycle", respCyc, 32'd2);
      checkVal("lw_data",  rdata, 32'h8899AABB);
      checkVal("lw_rdmask", {16'b0, rdMask}, 32'h0002);
      checkVal("lw_wrmask", {16'b0, wrMask}, 32'h0000);
      checkVal("lw_addr",  addrSeen, 32'd3);
      checkVal("lw_err",   {31'b0, err}, 32'd0);

      // sub-word loads
      runReq(1'b0, 2'b10, 1'b1, 32'h05, 32'h0, respCyc, rdata, err, rdMask, wrMask, mbBad, addrSeen);
      checkVal("lb_data", rdata, 32'hFFFFFF80);
      checkVal("lb_cycle", respCyc, 32'd2);
      runReq(1'b0, 2'b10, 1'b0, 32'h05, 32'h0, respCyc, rdata, err, rdMask, wrMask, mbBad, addrSeen);
      checkVal("lbu_data", rdata, 32'h00000080);
      runReq(1'b0, 2'b01, 1'b1, 32'h06, 32'h0, respCyc, rdata, err, rdMask, wrMask, mbBad, addrSeen);
      checkVal("lh_hi_data", rdata, 32'h000000F0);
      runReq(1'b0, 2'b01, 1'b1, 32'h04, 32'h0, respCyc, rdata, err, rdMask, wrMask, mbBad, addrSeen);
      checkVal("lh_lo_data", rdata, 32'hFFFF8000);
      runReq(1'b0, 2'b01, 1'b0, 32'h04, 32'h0, respCyc, rdata, err, rdMask, wrMask, mbBad, addrSeen);
      checkVal("lhu_lo_data", rdata, 32'h00008000);

      // sub-word store read-modify-write
      runReq(1'b1, 2'b10, 1'b0, 32'h09, 32'h000000AB, respCyc, rdata, err, rdMask, wrMask, mbBad, addrSeen);
      checkVal("sb_cycle",  respCyc, 32'd3);
      checkVal("sb_rdmask", {16'b0, rdMask}, 32'h0002);
      checkVal("sb_wrmask", {16'b0, wrMask}, 32'h0004);
      checkVal("sb_mbyte",  {31'b0, mbBad}, 32'd0);
      checkVal("sb_rdata",  rdata, 32'd0);
      checkVal("sb_mem",    mem[2], 32'h1122AB44);
      runReq(1'b1, 2'b01, 1'b0, 32'h0A, 32'h0000CDEF, respCyc, rdata, err, rdMask, wrMask, mbBad, addrSeen);
      checkVal("sh_cycle",  respCyc, 32'd3);
      checkVal("sh_addr",   addrSeen, 32'd2);
      checkVal("sh_mem",    mem[2], 32'hCDEFAB44);

      // misaligned
      runReq(1'b1, 2'b00, 1'b0, 32'h06, 32'h12345678, respCyc, rdata, err, rdMask, wrMask, mbBad, addrSeen);
      checkVal("sw_mis_cycle", respCyc, 32'd1);
      checkVal("sw_mis_err",   {31'b0, err}, 32'd1);
      checkVal("sw_mis_strb",  {16'b0, rdMask | wrMask}, 32'd0);
      checkVal("sw_mis_mem",   mem[1], 32'h00F08000);
      runReq(1'b0, 2'b01, 1'b0, 32'h03, 32'h0, respCyc, rdata, err, rdMask, wrMask, mbBad, addrSeen);
      checkVal("lh_mis_cycle", respCyc, 32'd1);
      checkVal("lh_mis_err",   {31'b0, err}, 32'd1);
      checkVal("lh_mis_rdata", rdata, 32'd0);
      checkVal("lh_mis_strb",  {16'b0, rdMask | wrMask}, 32'd0);

      // reset during READ of a sub-word store
      @(negedge Clk);
      ReqWrite = 1'b1; ReqSize = 2'b10; ReqSigned = 1'b0; ReqAddr = 32'h08; ReqWData = 32'h55;
      ReqValid = 1'b1;
      @(posedge Clk);
      #1 ReqValid = 1'b0;
      @(negedge Clk);
      checkVal("rst_mid_read", {31'b0, MemRead}, 32'd1);
      Reset = 1'b1;
      @(posedge Clk);
      #1 Reset = 1'b0;
      @(negedge Clk);
      checkVal("rst_mid_ready", {31'b0, ReqReady}, 32'd1);
      sawBad = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (MemWrite || RespValid) sawBad = 1'b1;
         @(negedge Clk);
      end
      checkVal("rst_mid_quiet", {31'b0, sawBad}, 32'd0);
      checkVal("rst_mid_mem",   mem[2], 32'hCDEFAB44);

      // request coinciding with reset is dropped
      ReqWrite = 1'b0; ReqSize = 2'b00; ReqAddr = 32'h0C; ReqValid = 1'b1; Reset = 1'b1;
      @(posedge Clk);
      #1 Reset = 1'b0; ReqValid = 1'b0;
      @(negedge Clk);
      checkVal("rst_drop_read",  {31'b0, MemRead}, 32'd0);
      checkVal("rst_drop_ready", {31'b0, ReqReady}, 32'd1);

      // back-to-back sw then lw with ReqValid held high
      @(negedge Clk);
      ReqWrite = 1'b1; ReqSize = 2'b00; ReqSigned = 1'b0; ReqAddr = 32'h10; ReqWData = 32'hDEADBEEF;
      ReqValid = 1'b1;
      @(posedge Clk);
      #1 ReqWrite = 1'b0; ReqWData = 32'h0;
      validTrace = '0; readyTrace = '0; secondData = '0;
      for (int c = 1; c <= 7; c++) begin
         @(negedge Clk);
         validTrace[c] = RespValid;
         readyTrace[c] = ReqReady;
         if (c == 5) secondData = RespRData;
         if (c == 4) ReqValid = 1'b0;
      end
      checkVal("b2b_valid", {24'b0, validTrace}, 32'h24);
      checkVal("b2b_ready", {24'b0, readyTrace}, 32'hC8);
      checkVal("b2b_data",  secondData, 32'hDEADBEEF);
      checkVal("b2b_mem",   mem[4], 32'hDEADBEEF);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
